// File: rtl/port_rd_backend_if.sv
// Egress engine bundle: scheduler inputs, queue-manager pop, SRAM word
// stream in, and the replayed packet stream out.
interface port_rd_backend_if #(
    parameter int DATA_W = 16
);
    logic              wrr_en;
    logic              ready;
    logic [7:0]        queue_nonempty;
    logic              pop_req;
    logic [2:0]        pop_prior;
    logic              in_vld;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;
    logic              rd_sop;
    logic              rd_eop;
    logic              rd_vld;
    logic [DATA_W-1:0] rd_data;
    logic              busy;

    // Environment side: scheduler hints and the SRAM word source.
    modport master (
        output wrr_en, ready, queue_nonempty, in_vld, in_data, in_last,
        input  pop_req, pop_prior, in_ready, rd_sop, rd_eop, rd_vld, rd_data, busy
    );

    // Engine side.
    modport slave (
        input  wrr_en, ready, queue_nonempty, in_vld, in_data, in_last,
        output pop_req, pop_prior, in_ready, rd_sop, rd_eop, rd_vld, rd_data, busy
    );
endinterface

// File: rtl/port_rd_backend.sv
// Per-port egress engine: picks one of 8 queues (strict priority or WRR),
// pops one packet, buffers its words in a small FIFO and replays it as
// rd_sop / rd_vld+rd_data / rd_eop.
module port_rd_backend #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    port_rd_backend_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, SOP, DATA, EOP} state_t;

    localparam int AW = $clog2(FIFO_DEPTH);

    state_t            state;
    logic [DATA_W:0]   mem [FIFO_DEPTH];   // {last, data}
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic              full;
    logic              push, pop;
    logic              last_acc;           // last word of packet already taken in
    logic              last_out;           // last word already driven on rd_data

    logic [7:0][3:0]   credit;
    logic [7:0]        has_credit;
    logic [7:0]        elig;
    logic              reload;
    logic              grant_ev;
    logic [2:0]        grant;

    function automatic logic [2:0] lowest(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (v[i]) r = 3'(i);
        return r;
    endfunction

    assign full        = (count == (AW+1)'(FIFO_DEPTH));
    assign bus.in_ready = ((state == SOP) || (state == DATA)) && !full && !last_acc;
    assign push        = bus.in_vld && bus.in_ready;
    assign pop         = (state == DATA) && (count != '0) && !last_out;
    assign grant_ev    = (state == IDLE) && bus.ready && (|bus.queue_nonempty);

    // Queue selection: strict lowest-index, or lowest-index with credit left
    // (reloading everything when no nonempty queue has credit).
    always_comb begin
        for (int q = 0; q < 8; q++) has_credit[q] = (credit[q] != 4'd0);
        elig   = bus.queue_nonempty & has_credit;
        reload = bus.wrr_en && (elig == 8'd0);
        grant  = lowest(bus.queue_nonempty);
        if (bus.wrr_en && !reload) grant = lowest(elig);
    end

    // WRR credits: weight 8-q, consumed one per grant, frozen in strict mode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int q = 0; q < 8; q++) credit[q] <= 4'(8 - q);
        end else if (grant_ev && bus.wrr_en) begin
            for (int q = 0; q < 8; q++) begin
                if (reload)
                    credit[q] <= (3'(q) == grant) ? 4'(7 - q) : 4'(8 - q);
                else if (3'(q) == grant)
                    credit[q] <= credit[q] - 4'd1;
            end
        end
    end

    // Word FIFO; simultaneous push and pop keep the count steady.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {bus.in_last, bus.in_data};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Packet FSM with registered framing outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.pop_req   <= 1'b0;
            bus.pop_prior <= 3'd0;
            bus.rd_sop    <= 1'b0;
            bus.rd_eop    <= 1'b0;
            bus.rd_vld    <= 1'b0;
            bus.rd_data   <= '0;
            bus.busy      <= 1'b0;
            last_acc      <= 1'b0;
            last_out      <= 1'b0;
        end else begin
            bus.pop_req <= 1'b0;
            bus.rd_sop  <= 1'b0;
            bus.rd_eop  <= 1'b0;
            bus.rd_vld  <= 1'b0;
            if (push && bus.in_last) last_acc <= 1'b1;
            case (state)
                IDLE: if (grant_ev) begin
                    state         <= SOP;
                    bus.pop_req   <= 1'b1;
                    bus.pop_prior <= grant;
                    bus.rd_sop    <= 1'b1;
                    bus.busy      <= 1'b1;
                    last_acc      <= 1'b0;
                    last_out      <= 1'b0;
                end
                SOP: state <= DATA;
                DATA: begin
                    if (last_out) begin
                        state      <= EOP;
                        bus.rd_eop <= 1'b1;
                    end else if (pop) begin
                        bus.rd_vld  <= 1'b1;
                        bus.rd_data <= mem[rd_ptr][DATA_W-1:0];
                        if (mem[rd_ptr][DATA_W]) last_out <= 1'b1;
                    end
                end
                EOP: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_port_rd_backend.sv
// Scoreboard bench for port_rd_backend: stimulus pushes expected SOP/word/EOP
// events, a negedge monitor pops and compares whenever the DUT frames output.
module tb_port_rd_backend;
    localparam int K_SOP = 0, K_DAT = 1, K_EOP = 2;

    typedef struct {
        int kind;
        int val;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0, n_pass = 0;
    bit   mon_en = 1'b1;
    bit   prev_vld = 1'b0;
    exp_t exp_q[$];

    port_rd_backend_if #(.DATA_W(16)) bus ();

    port_rd_backend #(.FIFO_DEPTH(4), .DATA_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, req);
    endtask

    task automatic expect_pkt(input int prio, input int n, input logic [15:0] base);
        exp_q.push_back('{K_SOP, prio});
        for (int i = 0; i < n; i++) exp_q.push_back('{K_DAT, int'(base + 16'(i))});
        exp_q.push_back('{K_EOP, 0});
    endtask

    // Monitor: every framed output event must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (bus.rd_sop || bus.rd_vld || bus.rd_eop) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", {bus.rd_sop, bus.rd_vld, bus.rd_eop}, 0);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.rd_sop) begin
                        chk("sop_order", K_SOP, e.kind);
                        chk("sop_pop_req", bus.pop_req, 1);
                        chk("sop_pop_prior", bus.pop_prior, e.val);
                    end else if (bus.rd_vld) begin
                        chk("data_order", K_DAT, e.kind);
                        chk("rd_data", bus.rd_data, e.val);
                    end else begin
                        chk("eop_order", K_EOP, e.kind);
                        chk("eop_after_last_vld", prev_vld, 1);
                    end
                end
            end
            prev_vld = bus.rd_vld;
        end
    end

    task automatic feed(input int n, input logic [15:0] base, input bit give_last);
        int i = 0;
        int t = 0;
        logic acc;
        while (i < n && t < 200) begin
            bus.in_vld  = 1'b1;
            bus.in_data = base + 16'(i);
            bus.in_last = give_last && (i == n - 1);
            acc = bus.in_ready;
            @(negedge clk);
            t++;
            if (acc) i++;
        end
        bus.in_vld  = 1'b0;
        bus.in_last = 1'b0;
        if (i < n) chk("feed_timeout", i, n);
    endtask

    task automatic wait_pop();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.pop_req && t < 20);
        if (!bus.pop_req) chk("pop_req_timeout", bus.pop_req, 1);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (bus.busy && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk("return_to_idle", bus.busy, 0);
    endtask

    task automatic run_pkt(input logic [7:0] qne, input bit wrr, input int prio,
                           input int n, input logic [15:0] base);
        expect_pkt(prio, n, base);
        bus.queue_nonempty = qne;
        bus.wrr_en         = wrr;
        bus.ready          = 1'b1;
        wait_pop();
        bus.ready = 1'b0;
        feed(n, base, 1'b1);
        wait_idle();
    endtask

    initial begin
        int cnt;
        int seq[$];

        bus.wrr_en = 1'b0;
        bus.ready = 1'b0;
        bus.queue_nonempty = 8'h00;
        bus.in_vld = 1'b0;
        bus.in_data = 16'h0;
        bus.in_last = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_outputs",
            {bus.pop_req, bus.pop_prior, bus.rd_sop, bus.rd_eop, bus.rd_vld,
             bus.rd_data, bus.busy, bus.in_ready}, 0);
        @(negedge clk);

        // Strict priority: 8'hA4 -> queue 2.
        run_pkt(8'hA4, 1'b0, 2, 3, 16'h0100);
        run_pkt(8'h80, 1'b0, 7, 2, 16'h0200);

        // Single-word packet.
        run_pkt(8'h08, 1'b0, 3, 1, 16'h1234);

        // ready=0 holds off the scheduler; ready=1 -> SOP next cycle.
        bus.queue_nonempty = 8'h10;
        bus.ready = 1'b0;
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.pop_req || bus.rd_sop) cnt++;
        end
        chk("no_pop_when_not_ready", cnt, 0);
        expect_pkt(4, 2, 16'h0400);
        bus.ready = 1'b1;
        @(negedge clk);
        chk("sop_next_cycle", bus.rd_sop, 1);
        bus.ready = 1'b0;
        feed(2, 16'h0400, 1'b1);
        wait_idle();

        // Backpressure: 10-word packet with in_vld held.
        run_pkt(8'h02, 1'b0, 1, 10, 16'h0A00);

        // WRR: 36 grants 0x8, 1x7, ..., 7x1, then queue 0 again.
        for (int q = 0; q < 8; q++)
            for (int k = 0; k < 8 - q; k++) seq.push_back(q);
        seq.push_back(0);
        foreach (seq[p]) run_pkt(8'hFF, 1'b1, seq[p], 1, 16'h5000 + 16'(p));
        bus.wrr_en = 1'b0;

        // Reset mid-DATA: abandon packet, outputs clear, next packet clean.
        mon_en = 1'b0;
        bus.queue_nonempty = 8'h01;
        bus.ready = 1'b1;
        wait_pop();
        bus.ready = 1'b0;
        feed(3, 16'hAA00, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midpkt_reset_outputs",
            {bus.pop_req, bus.pop_prior, bus.rd_sop, bus.rd_eop, bus.rd_vld,
             bus.rd_data, bus.busy, bus.in_ready}, 0);
        exp_q.delete();
        prev_vld = 1'b0;
        mon_en = 1'b1;
        run_pkt(8'h01, 1'b0, 0, 4, 16'hBB00);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
